// File: rtl/counter_preset_ctrl.sv
// Programmable start/end sequencer placed in front of a free-running sync up counter.
// Define COUNTER_PRESET_CTRL_ERR_EN to enable count-sequence error tracking on err_out.
module counter_preset_ctrl #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_al_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] start_val_in,
  input  logic [WIDTH-1:0] end_val_in,
  input  logic             reload_in,
  input  logic             stop_in,
  input  logic [WIDTH-1:0] count_in,
  output logic             load_out,
  output logic [WIDTH-1:0] d_out,
  output logic             ready_out,
  output logic             busy_out,
  output logic             tick_out,
  output logic             done_out,
  output logic [CNT_W-1:0] run_cnt_out,
  output logic             err_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_q, end_q;
  logic             reload_q;
  logic             accept_c, hit_c, tick_d, done_d;

  // Counter preset is always the latched start value; load_out decides when it is used.
  assign d_out = start_q;
  assign hit_c = (count_in == end_q);

  // Next-state and handshake decode; the terminal hit is Mealy on count_in.
  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    ready_out = 1'b0;
    busy_out  = 1'b0;
    accept_c  = 1'b0;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        ready_out = 1'b1;
        load_out  = 1'b1;
        if (start_in) begin
          accept_c = 1'b1;
          state_d  = ARM;
        end
      end
      ARM: begin
        busy_out = 1'b1;
        load_out = 1'b1;
        state_d  = stop_in ? IDLE : RUN;
      end
      RUN: begin
        busy_out = 1'b1;
        if (stop_in) begin
          load_out = 1'b1;
          state_d  = IDLE;
        end else if (hit_c) begin
          load_out = 1'b1;
          tick_d   = 1'b1;
          if (!reload_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        load_out = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  // State, run configuration and pulse/tally registers.
  always_ff @(posedge clk) begin
    if (!reset_al_in) begin
      state_q     <= IDLE;
      start_q     <= '0;
      end_q       <= '0;
      reload_q    <= 1'b0;
      tick_out    <= 1'b0;
      done_out    <= 1'b0;
      run_cnt_out <= '0;
    end else begin
      state_q  <= state_d;
      tick_out <= tick_d;
      done_out <= done_d;
      if (accept_c) begin
        start_q     <= start_val_in;
        end_q       <= end_val_in;
        reload_q    <= reload_in;
        run_cnt_out <= '0;
      end else if (tick_d && (run_cnt_out != CNT_MAX)) begin
        run_cnt_out <= run_cnt_out + CNT_W'(1);
      end
    end
  end

`ifdef COUNTER_PRESET_CTRL_ERR_EN
  logic [WIDTH-1:0] exp_q;

  // Predict the next count; any RUN-cycle disagreement latches err_out until the next accept.
  always_ff @(posedge clk) begin
    if (!reset_al_in) begin
      exp_q   <= '0;
      err_out <= 1'b0;
    end else begin
      if (accept_c) begin
        err_out <= 1'b0;
      end else if ((state_q == RUN) && (count_in != exp_q)) begin
        err_out <= 1'b1;
      end
      if (state_q == ARM) begin
        exp_q <= start_q;
      end else if (state_q == RUN) begin
        exp_q <= (hit_c && reload_q) ? start_q : count_in + WIDTH'(1);
      end
    end
  end
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_counter_preset_ctrl.sv
// Scoreboard bench for counter_preset_ctrl driving a behavioural 3-bit up counter.
// Ticks are predicted from the period rule and checked by an independent monitor.
module tb_counter_preset_ctrl;

  localparam int unsigned W  = 3;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset_al_in, start_in, reload_in, stop_in;
  logic [W-1:0]  start_val_in, end_val_in, count_in, d_out;
  logic          load_out, ready_out, busy_out, tick_out, done_out, err_out;
  logic [CW-1:0] run_cnt_out;

  counter_preset_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset_al_in(reset_al_in), .start_in(start_in),
    .start_val_in(start_val_in), .end_val_in(end_val_in), .reload_in(reload_in),
    .stop_in(stop_in), .count_in(count_in), .load_out(load_out), .d_out(d_out),
    .ready_out(ready_out), .busy_out(busy_out), .tick_out(tick_out),
    .done_out(done_out), .run_cnt_out(run_cnt_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  // Downstream counter; skip_en makes it jump 3->5 to emulate a faulty counter.
  logic [W-1:0] cnt = '0;
  bit           skip_en = 1'b0;
  always @(posedge clk) begin
    if (load_out)                    cnt <= d_out;
    else if (skip_en && cnt == 3'd3) cnt <= 3'd5;
    else                             cnt <= cnt + 3'd1;
  end
  assign count_in = cnt;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int cnt;
    bit done;
  } ev_t;

  ev_t sb_q[$];
  ev_t mon_e;
  ev_t push_e;
  int  n_chk = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every tick/done pulse must match the oldest predicted event.
  always @(negedge clk) begin
    if (mon_en && (tick_out === 1'b1 || done_out === 1'b1)) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("tick_cycle", cyc, mon_e.c);
        chk("tick_level", {31'd0, tick_out}, 1);
        chk("tick_run_cnt", {24'd0, run_cnt_out}, mon_e.cnt);
        chk("tick_done", {31'd0, done_out}, {31'd0, mon_e.done});
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int period(input logic [W-1:0] sv, input logic [W-1:0] ev);
    return ((int'(ev) - int'(sv) + 8) % 8) + 1;
  endfunction

  // One run: s = RUN-cycle index where stop (or reset) is applied, -1 for none.
  task automatic run_txn(input logic [W-1:0] sv, input logic [W-1:0] ev, input bit rl,
                         input int s, input bit use_rst, input bit ign, input bit skp);
    int  p, a, k, end_j;
    bit  by_rst;
    logic exp_err;
    p = period(sv, ev);
    chk("ready_before", {31'd0, ready_out}, 1);
    skip_en      = skp;
    start_val_in = sv;
    end_val_in   = ev;
    reload_in    = rl;
    start_in     = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    start_in = 1'b0;
    chk("sb_drained", sb_q.size(), 0);
    chk("arm_busy", {31'd0, busy_out}, 1);
    chk("arm_ready", {31'd0, ready_out}, 0);
    chk("arm_load", {31'd0, load_out}, 1);
    chk("arm_d", {29'd0, d_out}, {29'd0, sv});
    chk("arm_err", {31'd0, err_out}, 0);
    chk("arm_run_cnt", {24'd0, run_cnt_out}, 0);

    // Reference: a hit lands on every p-th RUN cycle, unless stop/reset arrives first.
    k = 0;
    for (int j = 0; (s < 0) || (j < s); j++) begin
      if ((j + 1) % p == 0) begin
        k++;
        push_e.c    = a + 2 + j;
        push_e.cnt  = (k > 255) ? 255 : k;
        push_e.done = !rl;
        sb_q.push_back(push_e);
        if (!rl) break;
      end
    end
    end_j  = (s >= 0 && (rl || s <= p - 1)) ? s : p - 1;
    by_rst = use_rst && (s >= 0) && (s == end_j);

    if (ign && s >= 3) begin
      wait_cyc(a + 2);
      start_val_in = ~sv;
      end_val_in   = ~ev;
      reload_in    = ~rl;
      start_in     = 1'b1;
      wait_cyc(a + 3);
      start_in = 1'b0;
    end
    if (s >= 0 && s == end_j) begin
      wait_cyc(a + 1 + s);
      if (use_rst) reset_al_in = 1'b0;
      else         stop_in = 1'b1;
    end
    wait_cyc(a + 2 + end_j);
    stop_in     = 1'b0;
    reset_al_in = 1'b1;

`ifdef COUNTER_PRESET_CTRL_ERR_EN
    exp_err = skp && !by_rst;
`else
    exp_err = 1'b0;
`endif
    chk("end_ready", {31'd0, ready_out}, 1);
    chk("end_busy", {31'd0, busy_out}, 0);
    chk("end_load", {31'd0, load_out}, 1);
    chk("end_err", {31'd0, err_out}, {31'd0, exp_err});
    if (by_rst) begin
      chk("rst_d", {29'd0, d_out}, 0);
      chk("rst_run_cnt", {24'd0, run_cnt_out}, 0);
      chk("rst_tick", {31'd0, tick_out}, 0);
      chk("rst_done", {31'd0, done_out}, 0);
    end else begin
      chk("end_d", {29'd0, d_out}, {29'd0, sv});
      chk("end_parked", {29'd0, count_in}, {29'd0, sv});
      chk("end_run_cnt", {24'd0, run_cnt_out}, (k > 255) ? 255 : k);
    end
    skip_en = 1'b0;
  endtask

  initial begin
    logic [W-1:0] sv, ev;
    bit rl;
    int p, s;
    reset_al_in  = 1'b0;
    start_in     = 1'b0;
    stop_in      = 1'b0;
    reload_in    = 1'b0;
    start_val_in = '0;
    end_val_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load", {31'd0, load_out}, 1);
    chk("rst_d0", {29'd0, d_out}, 0);
    chk("rst_ready", {31'd0, ready_out}, 1);
    chk("rst_busy", {31'd0, busy_out}, 0);
    chk("rst_tick0", {31'd0, tick_out}, 0);
    chk("rst_done0", {31'd0, done_out}, 0);
    chk("rst_cnt0", {24'd0, run_cnt_out}, 0);
    chk("rst_err0", {31'd0, err_out}, 0);
    reset_al_in = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    run_txn(3'd2, 3'd5, 1'b1, 13, 1'b0, 1'b0, 1'b0);
    run_txn(3'd6, 3'd1, 1'b1, 9, 1'b0, 1'b0, 1'b0);
    run_txn(3'd3, 3'd3, 1'b1, 300, 1'b0, 1'b0, 1'b0);
    run_txn(3'd0, 3'd7, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    run_txn(3'd1, 3'd4, 1'b1, 7, 1'b0, 1'b1, 1'b0);
    run_txn(3'd2, 3'd6, 1'b1, 6, 1'b1, 1'b0, 1'b0);
    run_txn(3'd1, 3'd6, 1'b1, 4, 1'b0, 1'b0, 1'b1);
    run_txn(3'd4, 3'd5, 1'b0, 3, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      sv = 3'($urandom_range(0, 7));
      ev = 3'($urandom_range(0, 7));
      rl = 1'($urandom_range(0, 1));
      p  = period(sv, ev);
      if (rl)                         s = int'($urandom_range(0, 3 * p + 2));
      else if ($urandom_range(0, 1)) s = -1;
      else                            s = int'($urandom_range(0, p));
      run_txn(sv, ev, rl, s, ($urandom_range(0, 7) == 0), 1'b1, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_preset_ctrl.md
Name: counter_preset_ctrl

Overview:
- Control stage placed directly upstream of the 3-bit sync up counter.
- Drives the counter's load_in and d_in, and monitors its count_out.
- Turns the free-running counter into a programmable start/end sequencer with one-shot and auto-reload modes, a per-period tick, a run-complete pulse and a completed-period tally.
- Software-side start/stop is handled through a ready/start handshake.

Parameters:
- WIDTH, 3, counter width; d_out, count_in, start_val_in and end_val_in are all this width.
- CNT_W, 8, width of run_cnt_out (saturating period tally).

Ports:
- clk  in  1  rising-edge clock, shared with the counter.
- reset_al_in  in  1  synchronous active-low reset.
- start_in  in  1  start request; accepted only when ready_out=1.
- start_val_in  in  WIDTH  preset value, sampled on accept.
- end_val_in  in  WIDTH  terminal value, sampled on accept.
- reload_in  in  1  sampled on accept: 1=auto-reload, 0=one-shot.
- stop_in  in  1  abort current run.
- count_in  in  WIDTH  counter's count_out.
- load_out  out  1  to counter load_in.
- d_out  out  WIDTH  to counter d_in; always equals the latched start value.
- ready_out  out  1  high in IDLE.
- busy_out  out  1  high in ARM or RUN.
- tick_out  out  1  registered one-cycle pulse per terminal hit.
- done_out  out  1  registered one-cycle pulse at one-shot completion.
- run_cnt_out  out  CNT_W  completed periods, saturating.
- err_out  out  1  sequence error flag (see Optional Feature).

Behaviour:
- Reset (reset_al_in=0 at a clk edge):
  - state=IDLE.
  - Latched start, end and reload cleared to 0.
  - tick_out=0, done_out=0, run_cnt_out=0, err_out=0.
  - Combinational outputs follow state, so after that edge: load_out=1, d_out=0, ready_out=1, busy_out=0.
  - Reset mid-run aborts immediately; no tick or done is produced.
- States:
  - IDLE: load_out=1, parking the counter at the latched start value. If start_in=1, latch start_val_in, end_val_in and reload_in, clear run_cnt_out, and go to ARM. stop_in is ignored.
  - ARM: exactly one cycle. load_out=1 with the new d_out, then go to RUN. The counter equals start at the first RUN cycle.
  - RUN: load_out=0 except on a hit. A hit is count_in==latched end, compared combinationally (Mealy).
    - Hit with reload=1: load_out=1 that cycle; stay in RUN.
    - Hit with reload=0: load_out=1 that cycle; go to IDLE.
- Period:
  - Period = ((end - start) mod 2^WIDTH) + 1 cycles.
  - Wrap through 0 is legal; start=6, end=1 gives 6,7,0,1.
  - start==end gives period 1: the counter is reloaded every cycle and tick_out stays high continuously.
- Outputs on a hit in RUN:
  - tick_out=1 on the next cycle.
  - run_cnt_out increments on the next cycle, saturating at 2^CNT_W-1.
  - One-shot mode only: done_out=1 on the next cycle, coincident with the last tick.
- stop_in:
  - In ARM or RUN, stop_in=1 forces IDLE next cycle, with load_out=1 that cycle.
  - stop beats a simultaneous hit: no tick, no done, no increment.
- start_in while busy is ignored; no queueing.
- The latched start, end and reload values cannot change during a run.

Optional Feature:
- COUNTER_PRESET_CTRL_ERR_EN defined:
  - Tracks the expected count.
  - Expected = start at the first RUN cycle and after every reload.
  - Otherwise expected = previous count_in + 1 (mod 2^WIDTH).
  - Any RUN-cycle mismatch sets err_out sticky. err_out clears only on reset or on a new accept.
  - Catches a counter that was async-reset externally or skipped a count.
- Undefined: no tracking logic; err_out tied 0.

Test Plan:
- start=2, end=5, reload=1 → count 2,3,4,5,2,3,…; tick_out every 4 cycles; run_cnt_out 1,2,3 after three periods.
- start=6, end=1, reload=1 → count 6,7,0,1,6; tick period 4; no err_out.
- start=3, end=3, reload=1 → count held at 3; tick_out continuously 1; run_cnt_out saturates at 255 after 255 hits.
- start=0, end=7, reload=0 → 8 RUN cycles; tick_out and done_out pulse together once; ready_out=1 next cycle; counter parked at 0.
- start=1, end=4, reload=1; stop_in asserted on the cycle count_in=4 → no tick, no increment, IDLE next cycle. Also: start_in pulsed during RUN is ignored.
- Mid-RUN reset_al_in=0 for one cycle → all registered outputs 0, IDLE, load_out=1. With ERR_EN, forcing count_in to skip 3→5 sets err_out=1 until the next accept.
